// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the fetch controller and the program-counter sequencer.
// The controller drives control events; the sequencer returns the PC and RAS status.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            call;
  logic            ret;
  logic            trap;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic            ras_empty;
  logic            ras_full;
  logic            misaligned;
  logic            ras_underflow;

  modport master (
    output stall, redirect, redirect_target, call, ret, trap,
    input  pc_out, pc_valid, ras_empty, ras_full, misaligned, ras_underflow
  );

  modport slave (
    input  stall, redirect, redirect_target, call, ret, trap,
    output pc_out, pc_valid, ras_empty, ras_full, misaligned, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program counter with trap/redirect/stall priority and a circular
// return-address stack that overwrites its oldest entry when pushed while full.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INC_BYTES    = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);
  localparam int              PTR_W      = $clog2(RAS_DEPTH);
  localparam int              CNT_W      = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] INC        = XLEN'(INC_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RAS_DEPTH);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t           state, state_next;
  logic [XLEN-1:0]  pc, pc_next, pc_seq;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top, top_next, top_pop, push_ptr;
  logic [CNT_W-1:0] count, count_next, count_pop;
  logic             push;
  logic             mis, mis_next, unf, unf_next;
  logic             empty_r, full_r;

  assign pc_seq = pc + INC;

  always_comb begin
    state_next = S_RUN;
    pc_next    = pc;
    top_next   = top;
    count_next = count;
    top_pop    = top;
    count_pop  = count;
    push       = 1'b0;
    push_ptr   = top;
    mis_next   = 1'b0;
    unf_next   = 1'b0;
    case (state)
      S_WAIT: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        if (bus.trap) begin
          pc_next = TRAP_VECTOR;
        end else if (bus.redirect) begin
          pc_next  = bus.redirect_target & ~ALIGN_MASK;
          mis_next = |(bus.redirect_target & ALIGN_MASK);
          // A combined call+ret pops before pushing, so a live top entry is replaced in place.
          if (bus.ret && count != '0) begin
            top_pop   = top - PTR_W'(1);
            count_pop = count - CNT_W'(1);
          end
          top_next   = top_pop;
          count_next = count_pop;
          if (bus.call) begin
            push       = 1'b1;
            push_ptr   = top_pop + PTR_W'(1);
            top_next   = push_ptr;
            count_next = (count_pop == FULL_CNT) ? count_pop : count_pop + CNT_W'(1);
          end
        end else if (bus.ret) begin
          if (count != '0) begin
            pc_next    = ras_mem[top];
            top_next   = top - PTR_W'(1);
            count_next = count - CNT_W'(1);
          end else begin
            pc_next  = pc_seq;
            unf_next = 1'b1;
          end
        end else if (!bus.stall) begin
          pc_next = pc_seq;
        end
      end
      default: state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_WAIT;
      pc      <= RESET_VECTOR;
      top     <= '0;
      count   <= '0;
      mis     <= 1'b0;
      unf     <= 1'b0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      top     <= top_next;
      count   <= count_next;
      mis     <= mis_next;
      unf     <= unf_next;
      empty_r <= (count_next == '0);
      full_r  <= (count_next == FULL_CNT);
    end
  end

  // Stack contents are never cleared; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[push_ptr] <= pc_seq;
    end
  end

  assign bus.pc_out        = pc;
  assign bus.pc_valid      = (state == S_RUN);
  assign bus.ras_empty     = empty_r;
  assign bus.ras_full      = full_r;
  assign bus.misaligned    = mis;
  assign bus.ras_underflow = unf;
endmodule
